mag_bcd_convert: RTL and testbench

- Downstream stage of the 16-bit magnitude/sqrt unit. It consumes the fixed-point result, an integer part plus a 16-bit binary fraction, once the upstream flag says the result has converged.
- Converts the integer part to ID packed BCD digits using sequential double-dabble.
- Converts the fraction to FD decimal digits using sequential multiply-by-10.
- Feeds the board's 7-segment/LED display driver, which latches on done_o.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_add3_n.sv | 17 +
 rtl/mag_bcd_convert.sv | 155 +++++++++++++++
 tb/tb_mag_bcd_convert.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the magnitude-to-BCD conversion stage.
//   state_t    : conversion FSM states (IDLE, INT, FRAC, DONE)
//   digit_t    : one packed BCD digit
//   DEC_TEN    : multiplier used to extract fraction digits
//   add3_digit : double-dabble correction for a single nibble
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t DEC_TEN = 4'd10;

  // A digit of 5 or more would become >= 10 after the next left shift,
  // so pre-add 3 to make the shift carry into the next digit.
  function automatic digit_t add3_digit(input digit_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_add3_n.sv
// Combinational double-dabble correction across an N-digit packed BCD vector.
// Ports:
//   bcd_i : N packed BCD digits before correction
//   bcd_o : same digits with every digit >= 5 incremented by 3
module bcd_add3_n #(
  parameter int N = 6
) (
  input  logic [4*N-1:0] bcd_i,
  output logic [4*N-1:0] bcd_o
);
  import bcd_pkg::*;

  for (genvar gi = 0; gi < N; gi++) begin : g_digit
    assign bcd_o[4*gi +: 4] = add3_digit(bcd_i[4*gi +: 4]);
  end

endmodule

// File: rtl/mag_bcd_convert.sv
// Converts a fixed-point magnitude (integer part + binary fraction) into
// packed BCD for the display driver. The integer part uses sequential
// double-dabble (one bit per cycle), the fraction uses sequential
// multiply-by-10 (one digit per cycle, truncating).
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   valid_i   : input result valid (accepted when ready_o is high)
//   yint_i    : integer part, IW bits
//   ydec_i    : fraction part, value = ydec_i / 2^FW
//   ready_o   : high only while idle
//   done_o    : one-cycle pulse, outputs updated on the same edge
//   bcd_int_o : ID integer digits, most significant in the top nibble
//   bcd_dec_o : FD fraction digits, first digit after the point on top
//   ovf_o     : integer part was >= 10^ID
module mag_bcd_convert #(
  parameter int IW = 17,
  parameter int FW = 16,
  parameter int ID = 6,
  parameter int FD = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [IW-1:0]   yint_i,
  input  logic [FW-1:0]   ydec_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [4*ID-1:0] bcd_int_o,
  output logic [4*FD-1:0] bcd_dec_o,
  output logic            ovf_o
);
  import bcd_pkg::*;

  // One counter serves both the bit loop and the digit loop.
  localparam int CW = $clog2(((IW > FD) ? IW : FD) + 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     shift_q, shift_d;
  logic [4*ID-1:0]   bcd_q, bcd_d;
  logic [FW-1:0]     frac_q, frac_d;
  logic [4*FD-1:0]   dec_q, dec_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*ID-1:0]   bcd_int_q, bcd_int_d;
  logic [4*FD-1:0]   bcd_dec_q, bcd_dec_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [4*ID-1:0]   bcd_corr;
  logic [FW+3:0]     acc;

  bcd_add3_n #(.N(ID)) u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_corr)
  );

  // The top nibble of frac*10 is the next decimal digit; the low FW bits
  // are the remaining fraction (truncated, never rounded).
  assign acc = {4'b0000, frac_q} * {{FW{1'b0}}, DEC_TEN};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    frac_d    = frac_q;
    dec_d     = dec_q;
    ovf_acc_d = ovf_acc_q;
    cnt_d     = cnt_q;
    bcd_int_d = bcd_int_q;
    bcd_dec_d = bcd_dec_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          shift_d   = yint_i;
          bcd_d     = '0;
          frac_d    = ydec_i;
          dec_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = INT;
        end
      end
      INT: begin
        // A bit shifted out of the top digit means the value has passed
        // 10^ID; the digits keep only the value modulo 10^ID.
        ovf_acc_d = ovf_acc_q | bcd_corr[4*ID-1];
        bcd_d     = {bcd_corr[4*ID-2:0], shift_q[IW-1]};
        shift_d   = {shift_q[IW-2:0], 1'b0};
        if (cnt_q == CW'(IW - 1)) begin
          cnt_d   = '0;
          state_d = FRAC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FRAC: begin
        dec_d  = {dec_q[4*FD-5:0], acc[FW+3:FW]};
        frac_d = acc[FW-1:0];
        if (cnt_q == CW'(FD - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        bcd_int_d = bcd_q;
        bcd_dec_d = dec_q;
        ovf_d     = ovf_acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      frac_q    <= '0;
      dec_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
      bcd_int_q <= '0;
      bcd_dec_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      frac_q    <= frac_d;
      dec_q     <= dec_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
      bcd_int_q <= bcd_int_d;
      bcd_dec_q <= bcd_dec_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign done_o    = done_q;
  assign bcd_int_o = bcd_int_q;
  assign bcd_dec_o = bcd_dec_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_mag_bcd_convert.sv
// Scoreboard bench for mag_bcd_convert: a default instance (IW=17) and a
// wide instance (IW=20) that can reach the overflow range. Expected digits
// come from plain decimal arithmetic on the input values.
module tb_mag_bcd_convert;

  localparam int IW  = 17;
  localparam int IW2 = 20;
  localparam int FW  = 16;
  localparam int ID  = 6;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid1 = 1'b0, ready1, done1, ovf1;
  logic [IW-1:0] yint1 = '0;
  logic [15:0]   ydec1 = '0;
  logic [23:0]   bi1;
  logic [15:0]   bd1;

  logic           valid2 = 1'b0, ready2, done2, ovf2;
  logic [IW2-1:0] yint2 = '0;
  logic [15:0]    ydec2 = '0;
  logic [23:0]    bi2;
  logic [15:0]    bd2;

  mag_bcd_convert #(.IW(IW), .FW(FW), .ID(ID), .FD(FD)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid1), .yint_i(yint1), .ydec_i(ydec1),
    .ready_o(ready1), .done_o(done1), .bcd_int_o(bi1), .bcd_dec_o(bd1), .ovf_o(ovf1)
  );

  mag_bcd_convert #(.IW(IW2), .FW(FW), .ID(ID), .FD(FD)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid2), .yint_i(yint2), .ydec_i(ydec2),
    .ready_o(ready2), .done_o(done2), .bcd_int_o(bi2), .bcd_dec_o(bd2), .ovf_o(ovf2)
  );

  typedef struct {
    logic [23:0] bi;
    logic [15:0] bd;
    logic        ovf;
    int          t0;
    longint      y;
    longint      f;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2, etmp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [23:0] last_bi1 = '0, last_bi2 = '0;
  logic [15:0] last_bd1 = '0, last_bd2 = '0;
  logic        last_ovf1 = 1'b0, last_ovf2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits of y mod 10^6, floor(f * 10^4 / 2^16).
  function automatic exp_t model(longint y, longint f, int t0);
    exp_t   r;
    longint m;
    longint fr;
    r.bi = '0;
    r.bd = '0;
    m = y % 1000000;
    for (int i = 0; i < ID; i++) begin
      r.bi[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    fr = (f * 10000) / 65536;
    for (int i = 0; i < FD; i++) begin
      r.bd[4*i +: 4] = 4'(fr % 10);
      fr = fr / 10;
    end
    r.ovf = (y >= 1000000);
    r.t0  = t0;
    r.y   = y;
    r.f   = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Monitors: compare on every done pulse, and check outputs hold otherwise.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) fail_now("dut1_unexpected_done");
      else begin
        e1 = q1.pop_front();
        chk("dut1_bcd_int", 32'(bi1), 32'(e1.bi));
        chk("dut1_bcd_dec", 32'(bd1), 32'(e1.bd));
        chk("dut1_ovf", 32'(ovf1), 32'(e1.ovf));
        chk("dut1_latency", 32'(cyc - e1.t0), 32'(IW + FD + 1));
        $display("[TB] dut1 y=%0d f=%04h -> int=%06h dec=%04h ovf=%0b", e1.y, e1.f, bi1, bd1, ovf1);
        last_bi1 = e1.bi; last_bd1 = e1.bd; last_ovf1 = e1.ovf;
      end
    end else if (rst_n) begin
      chk("dut1_hold", 32'({ovf1, bd1, bi1} != {last_ovf1, last_bd1, last_bi1}), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) fail_now("dut2_unexpected_done");
      else begin
        e2 = q2.pop_front();
        chk("dut2_bcd_int", 32'(bi2), 32'(e2.bi));
        chk("dut2_bcd_dec", 32'(bd2), 32'(e2.bd));
        chk("dut2_ovf", 32'(ovf2), 32'(e2.ovf));
        chk("dut2_latency", 32'(cyc - e2.t0), 32'(IW2 + FD + 1));
        $display("[TB] dut2 y=%0d f=%04h -> int=%06h dec=%04h ovf=%0b", e2.y, e2.f, bi2, bd2, ovf2);
        last_bi2 = e2.bi; last_bd2 = e2.bd; last_ovf2 = e2.ovf;
      end
    end else if (rst_n) begin
      chk("dut2_hold", 32'({ovf2, bd2, bi2} != {last_ovf2, last_bd2, last_bi2}), 32'd0);
    end
  end

  // Drivers run on the falling edge; the DUT samples on the next rising edge.
  task automatic send1(input longint y, input longint f);
    int n = 0;
    while (!ready1 && n < 200) begin @(negedge clk); n++; end
    if (!ready1) begin fail_now("dut1_ready_timeout"); return; end
    valid1 = 1'b1; yint1 = IW'(y); ydec1 = 16'(f);
    q1.push_back(model(y, f, cyc + 1));
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic send2(input longint y, input longint f);
    int n = 0;
    while (!ready2 && n < 200) begin @(negedge clk); n++; end
    if (!ready2) begin fail_now("dut2_ready_timeout"); return; end
    valid2 = 1'b1; yint2 = IW2'(y); ydec2 = 16'(f);
    q2.push_back(model(y, f, cyc + 1));
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 2000) begin @(negedge clk); n++; end
    if (q1.size() != 0 || q2.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int guard;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready1), 32'd1);
    chk("reset_done", 32'(done1), 32'd0);
    chk("reset_outputs", 32'({ovf1, bd1, bi1} != '0), 32'd0);
    chk("reset_ready2", 32'(ready2), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    send1(5, 16'h8000);
    send1(131071, 16'hFFFF);
    send1(0, 16'h1999);
    send1(0, 16'h0001);
    send1(0, 16'h4000);
    send2(1000000, 16'h0000);
    send2(999999, 16'h0000);
    for (int i = 0; i < 10; i++) send2(longint'($urandom_range(0, 1048575)), longint'($urandom_range(0, 65535)));
    for (int i = 0; i < 20; i++) send1(longint'($urandom_range(0, 131071)), longint'($urandom_range(0, 65535)));
    drain();

    // valid_i during a conversion is ignored.
    send1(1234, 16'h1234);
    repeat (4) @(negedge clk);
    chk("busy_ready_low", 32'(ready1), 32'd0);
    valid1 = 1'b1; yint1 = IW'(777); ydec1 = 16'hBEEF;
    @(negedge clk);
    valid1 = 1'b0;
    drain();

    // valid_i held high: back-to-back conversions, ready high one cycle each.
    cnt = 0;
    guard = 0;
    valid1 = 1'b1; yint1 = IW'(54321); ydec1 = 16'hABCD;
    while (cnt < 3 && guard < 200) begin
      if (ready1) begin
        q1.push_back(model(54321, 16'hABCD, cyc + 1));
        cnt++;
        @(negedge clk);
        chk("held_ready_one_cycle", 32'(ready1), 32'd0);
        if (cnt == 3) valid1 = 1'b0;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    valid1 = 1'b0;
    if (cnt < 3) fail_now("held_accept_timeout");
    drain();

    // Reset in the middle of a conversion aborts it.
    send1(98765, 16'h7777);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    etmp = q1.pop_back();
    last_bi1 = '0; last_bd1 = '0; last_ovf1 = 1'b0;
    last_bi2 = '0; last_bd2 = '0; last_ovf2 = 1'b0;
    #1;
    chk("abort_outputs_zero", 32'({ovf1, bd1, bi1} != '0), 32'd0);
    chk("abort_done_low", 32'(done1), 32'd0);
    chk("abort_ready", 32'(ready1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready", 32'(ready1), 32'd1);
    repeat (40) @(negedge clk);
    chk("abort_outputs_after", 32'({ovf1, bd1, bi1} != '0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
